// File: rtl/sifh_peak_finder_pkg.sv
// Shared constants and state encoding for the SiFH histogram peak finder.
// Values match the ones the histogram FSM uses so both sides agree on widths.
package sifh_peak_finder_pkg;

    localparam int PIXEL_NUM_PER_RAM_DEF = 4;
    localparam int BIN_NUM_DEF           = 16;
    localparam int CNT_W_DEF             = 8;
    localparam int PIX_W_DEF             = $clog2(PIXEL_NUM_PER_RAM_DEF);
    localparam int BIN_W_DEF             = $clog2(BIN_NUM_DEF);
    localparam int RAM_ADDR              = PIX_W_DEF + BIN_W_DEF;
    localparam int peakMax               = CNT_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } pfState_e;

endpackage

// File: rtl/sifh_peak_finder_if.sv
// Histogram RAM port plus peak-result handshake seen by the peak finder.
// master = peak finder side, slave = RAM / result consumer side.
interface sifh_peak_finder_if
    import sifh_peak_finder_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int BIN_W = BIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic                   ram_ren;
    logic [PIX_W+BIN_W-1:0] ram_raddr;
    logic [CNT_W-1:0]       ram_rdata;
    logic                   ram_wen;
    logic [PIX_W+BIN_W-1:0] ram_waddr;
    logic [CNT_W-1:0]       ram_wdata;
    logic                   peak_valid;
    logic                   peak_ready;
    logic [PIX_W-1:0]       peak_pixel;
    logic [BIN_W-1:0]       peak_bin;
    logic [CNT_W-1:0]       peak_count;

    modport master (
        output ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata,
        output peak_valid, peak_pixel, peak_bin, peak_count,
        input  ram_rdata, peak_ready
    );

    modport slave (
        input  ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata,
        input  peak_valid, peak_pixel, peak_bin, peak_count,
        output ram_rdata, peak_ready
    );

endinterface

// File: rtl/sifh_max_tracker.sv
// Running maximum / arg-max over one pixel's bin samples.
// Strict greater-than compare, so ties keep the lower (earlier) bin.
module sifh_max_tracker
    import sifh_peak_finder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [CNT_W-1:0] sample,
    input  logic [BIN_W-1:0] bin,
    output logic [CNT_W-1:0] maxCount,
    output logic [BIN_W-1:0] maxBin
);

    logic [CNT_W-1:0] maxCountR;
    logic [BIN_W-1:0] maxBinR;

    // Running max register; clear has priority so each pixel starts from 0 / bin 0
    always_ff @(posedge clk) begin
        if (res) begin
            maxCountR <= {CNT_W{1'b0}};
            maxBinR   <= {BIN_W{1'b0}};
        end else if (clear) begin
            maxCountR <= {CNT_W{1'b0}};
            maxBinR   <= {BIN_W{1'b0}};
        end else if (sample_valid && (sample > maxCountR)) begin
            maxCountR <= sample;
            maxBinR   <= bin;
        end else begin
            maxCountR <= maxCountR;
            maxBinR   <= maxBinR;
        end
    end

    assign maxCount = maxCountR;
    assign maxBin   = maxBinR;

endmodule

// File: rtl/sifh_peak_finder.sv
// Scans every pixel's histogram bins, reports the peak bin per pixel over a
// valid/ready handshake and optionally zeroes each bin as it is read.
module sifh_peak_finder
    import sifh_peak_finder_pkg::*;
#(
    parameter int PIXEL_NUM_PER_RAM = PIXEL_NUM_PER_RAM_DEF,
    parameter int BIN_NUM           = BIN_NUM_DEF,
    parameter int CNT_W             = CNT_W_DEF,
    parameter int CLEAR_ON_READ     = 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    output logic                busy,
    output logic                done,
    sifh_peak_finder_if.master  bus
);

    localparam int PIX_W  = $clog2(PIXEL_NUM_PER_RAM);
    localparam int BIN_W  = $clog2(BIN_NUM);
    localparam int ADDR_W = PIX_W + BIN_W;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1'b1);
    localparam logic [BIN_W-1:0] BIN_ONE  = BIN_W'(1'b1);

    pfState_e          stateR;
    pfState_e          stateNextS;
    logic [PIX_W-1:0]  pixelR;
    logic [PIX_W-1:0]  pixelNextS;
    logic [BIN_W-1:0]  binR;
    logic [BIN_W-1:0]  binNextS;

    logic              ramRenR;
    logic [ADDR_W-1:0] ramRaddrR;
    logic              rdValidR;
    logic [ADDR_W-1:0] rdAddrR;
    logic              peakValidR;
    logic              busyR;
    logic              doneR;

    logic              trackClearS;
    logic [CNT_W-1:0]  maxCountS;
    logic [BIN_W-1:0]  maxBinS;

    // Next-state, pixel and bin counter logic
    always_comb begin
        stateNextS = stateR;
        pixelNextS = pixelR;
        binNextS   = binR;
        case (stateR)
            ST_IDLE: begin
                if (start) begin
                    stateNextS = ST_READ;
                    pixelNextS = {PIX_W{1'b0}};
                    binNextS   = {BIN_W{1'b0}};
                end else begin
                    stateNextS = ST_IDLE;
                end
            end
            ST_READ: begin
                binNextS = binR + BIN_ONE;
                if (binR == LAST_BIN) begin
                    stateNextS = ST_DRAIN;
                end else begin
                    stateNextS = ST_READ;
                end
            end
            ST_DRAIN: begin
                stateNextS = ST_EMIT;
            end
            ST_EMIT: begin
                if (bus.peak_ready) begin
                    if (pixelR == LAST_PIX) begin
                        stateNextS = ST_DONE;
                    end else begin
                        stateNextS = ST_READ;
                        pixelNextS = pixelR + PIX_ONE;
                        binNextS   = {BIN_W{1'b0}};
                    end
                end else begin
                    stateNextS = ST_EMIT;
                end
            end
            ST_DONE: begin
                stateNextS = ST_IDLE;
            end
            default: begin
                stateNextS = ST_IDLE;
            end
        endcase
    end

    // State and scan position registers
    always_ff @(posedge clk) begin
        if (res) begin
            stateR <= ST_IDLE;
            pixelR <= {PIX_W{1'b0}};
            binR   <= {BIN_W{1'b0}};
        end else begin
            stateR <= stateNextS;
            pixelR <= pixelNextS;
            binR   <= binNextS;
        end
    end

    // Strobes decoded from the next state so every output leaves a flop
    always_ff @(posedge clk) begin
        if (res) begin
            ramRenR    <= 1'b0;
            ramRaddrR  <= {ADDR_W{1'b0}};
            rdValidR   <= 1'b0;
            rdAddrR    <= {ADDR_W{1'b0}};
            peakValidR <= 1'b0;
            busyR      <= 1'b0;
            doneR      <= 1'b0;
        end else begin
            ramRenR    <= (stateNextS == ST_READ);
            ramRaddrR  <= {pixelNextS, binNextS};
            rdValidR   <= ramRenR;
            rdAddrR    <= ramRaddrR;
            peakValidR <= (stateNextS == ST_EMIT);
            busyR      <= (stateNextS != ST_IDLE);
            doneR      <= (stateNextS == ST_DONE);
        end
    end

    // The first read of a pixel never overlaps a returning sample, so clearing here is safe
    assign trackClearS = (stateR == ST_READ) && (binR == {BIN_W{1'b0}});

    sifh_max_tracker #(
        .CNT_W (CNT_W),
        .BIN_W (BIN_W)
    ) u_maxTracker (
        .clk          (clk),
        .res          (res),
        .clear        (trackClearS),
        .sample_valid (rdValidR),
        .sample       (bus.ram_rdata),
        .bin          (rdAddrR[BIN_W-1:0]),
        .maxCount     (maxCountS),
        .maxBin       (maxBinS)
    );

    // Clear write lands in the cycle the read data for that address returns
    assign bus.ram_ren    = ramRenR;
    assign bus.ram_raddr  = ramRaddrR;
    assign bus.ram_wen    = (CLEAR_ON_READ != 0) ? rdValidR : 1'b0;
    assign bus.ram_waddr  = rdAddrR;
    assign bus.ram_wdata  = {CNT_W{1'b0}};
    assign bus.peak_valid = peakValidR;
    assign bus.peak_pixel = pixelR;
    assign bus.peak_bin   = maxBinS;
    assign bus.peak_count = maxCountS;
    assign busy           = busyR;
    assign done           = doneR;

endmodule

// File: tb/tb_sifh_peak_finder.sv
// Bench for sifh_peak_finder: behavioural RAM, scoreboard of expected peaks
// filled when a scan is started, drained as results are accepted.
module tb_sifh_peak_finder;
    import sifh_peak_finder_pkg::*;

    localparam int PIXN  = 4;
    localparam int BINN  = 16;
    localparam int CW    = 8;
    localparam int PW    = 2;
    localparam int BW    = 4;
    localparam int AW    = 6;
    localparam int WORDS = 64;

    logic clk = 1'b0;
    logic res;
    logic start;
    logic busy;
    logic done;

    sifh_peak_finder_if #(.PIX_W(PW), .BIN_W(BW), .CNT_W(CW)) pf();

    sifh_peak_finder #(
        .PIXEL_NUM_PER_RAM (PIXN),
        .BIN_NUM           (BINN),
        .CNT_W             (CW),
        .CLEAR_ON_READ     (1)
    ) dut (
        .clk   (clk),
        .res   (res),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (pf)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] mem     [WORDS];
    logic [CW-1:0] refData [WORDS];
    logic          tbWe;
    logic [AW-1:0] tbWa;
    logic [CW-1:0] tbWd;

    // Synchronous-read RAM; bench preload has priority over the clear port
    always @(posedge clk) begin
        if (pf.ram_ren) pf.ram_rdata <= mem[pf.ram_raddr];
        if (tbWe) mem[tbWa] <= tbWd;
        else if (pf.ram_wen) mem[pf.ram_waddr] <= 8'd0;
    end

    int nCmp = 0;
    int nErr = 0;
    int doneCnt = 0;
    int resCnt = 0;
    logic [13:0] sbQ [$];
    logic [13:0] expR;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Accepted results are checked against the scoreboard head
    always @(negedge clk) begin
        if (!res && pf.peak_valid && pf.peak_ready) begin
            resCnt++;
            if (sbQ.size() == 0) begin
                checkVal("sbUnderflow", 32'(sbQ.size()), 32'd1);
            end else begin
                expR = sbQ.pop_front();
                checkVal("peakPixel", 32'(pf.peak_pixel), 32'(expR[13:12]));
                checkVal("peakBin",   32'(pf.peak_bin),   32'(expR[11:8]));
                checkVal("peakCount", 32'(pf.peak_count), 32'(expR[7:0]));
            end
        end
        if (!res && done) doneCnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRam();
        for (int i = 0; i < WORDS; i++) begin
            tbWe = 1'b1;
            tbWa = AW'(i);
            tbWd = refData[i];
            tick();
        end
        tbWe = 1'b0;
    endtask

    task automatic pushExpected();
        for (int p = 0; p < PIXN; p++) begin
            logic [CW-1:0] best;
            logic [BW-1:0] bestBin;
            best = 8'd0;
            bestBin = 4'd0;
            for (int b = 0; b < BINN; b++) begin
                if (refData[p*BINN + b] > best) begin
                    best = refData[p*BINN + b];
                    bestBin = b[BW-1:0];
                end
            end
            sbQ.push_back({p[PW-1:0], bestBin, best});
        end
    endtask

    task automatic startScan();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int base, input int resBase, input string tag);
        int n;
        n = 0;
        while (doneCnt == base && n < 400) begin
            tick();
            n++;
        end
        checkVal({tag, "Done"}, 32'(doneCnt - base), 32'd1);
        repeat (3) tick();
        checkVal({tag, "DoneOnce"}, 32'(doneCnt - base), 32'd1);
        checkVal({tag, "Results"}, 32'(resCnt - resBase), 32'd4);
        checkVal({tag, "IdleBusy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int base;
        int resBase;
        logic [PW-1:0] c0Pix;
        logic [BW-1:0] c0Bin;
        logic [CW-1:0] c0Cnt;

        res = 1'b1;
        start = 1'b0;
        pf.peak_ready = 1'b1;
        tbWe = 1'b0;
        tbWa = 6'd0;
        tbWd = 8'd0;
        repeat (3) tick();

        checkVal("rstRen",   32'(pf.ram_ren),    32'd0);
        checkVal("rstWen",   32'(pf.ram_wen),    32'd0);
        checkVal("rstValid", 32'(pf.peak_valid), 32'd0);
        checkVal("rstBusy",  32'(busy),          32'd0);
        checkVal("rstDone",  32'(done),          32'd0);
        checkVal("rstRaddr", 32'(pf.ram_raddr),  32'd0);
        checkVal("rstWaddr", 32'(pf.ram_waddr),  32'd0);
        checkVal("rstPixel", 32'(pf.peak_pixel), 32'd0);
        checkVal("rstBin",   32'(pf.peak_bin),   32'd0);
        checkVal("rstCount", 32'(pf.peak_count), 32'd0);
        res = 1'b0;
        tick();

        // Scan 1: single peak, tie, empty pixel, random pixel; ready held high
        for (int i = 0; i < WORDS; i++) refData[i] = 8'd0;
        for (int b = 0; b < BINN; b++) refData[b] = 8'd1;
        refData[5] = 8'd200;
        refData[16 + 3] = 8'd50;
        refData[16 + 9] = 8'd50;
        for (int b = 0; b < BINN; b++) refData[48 + b] = CW'($urandom_range(0, 255));
        loadRam();
        pushExpected();
        base = doneCnt;
        resBase = resCnt;
        startScan();
        checkVal("firstRen",  32'(pf.ram_ren),   32'd1);
        checkVal("firstAddr", 32'(pf.ram_raddr), 32'd0);
        checkVal("scanBusy",  32'(busy),         32'd1);
        n = 1;
        while (pf.peak_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkVal("firstLatency", 32'(n), 32'd18);
        waitDone(base, resBase, "scan1");
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== 8'd0) bad++;
        checkVal("ramCleared", 32'(bad), 32'd0);

        // Scan 2: backpressure in EMIT plus start pulses while busy
        for (int i = 0; i < WORDS; i++) refData[i] = CW'($urandom_range(0, 255));
        loadRam();
        pushExpected();
        base = doneCnt;
        resBase = resCnt;
        pf.peak_ready = 1'b0;
        startScan();
        n = 0;
        while (pf.peak_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkVal("stallReached", 32'(pf.peak_valid), 32'd1);
        c0Pix = pf.peak_pixel;
        c0Bin = pf.peak_bin;
        c0Cnt = pf.peak_count;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pf.peak_valid !== 1'b1 || pf.peak_pixel !== c0Pix || pf.peak_bin !== c0Bin ||
                pf.peak_count !== c0Cnt || pf.ram_ren !== 1'b0 || pf.ram_wen !== 1'b0) bad++;
        end
        checkVal("stallStable", 32'(bad), 32'd0);
        pf.peak_ready = 1'b1;
        tick();
        checkVal("resumeRen",  32'(pf.ram_ren),   32'd1);
        checkVal("resumeAddr", 32'(pf.ram_raddr), 32'd16);
        tick();
        startScan();
        repeat (5) tick();
        startScan();
        waitDone(base, resBase, "scan2");

        // Scan 3: reset in the middle of pixel 0, then a clean rescan
        for (int i = 0; i < WORDS; i++) refData[i] = CW'($urandom_range(0, 255));
        loadRam();
        pushExpected();
        base = doneCnt;
        startScan();
        repeat (7) tick();
        checkVal("midAddr", 32'(pf.ram_raddr), 32'd7);
        res = 1'b1;
        tick();
        res = 1'b0;
        sbQ.delete();
        checkVal("midRstRen",   32'(pf.ram_ren),    32'd0);
        checkVal("midRstWen",   32'(pf.ram_wen),    32'd0);
        checkVal("midRstValid", 32'(pf.peak_valid), 32'd0);
        checkVal("midRstBusy",  32'(busy),          32'd0);
        checkVal("midRstDone",  32'(done),          32'd0);
        repeat (30) tick();
        checkVal("midRstNoDone", 32'(doneCnt - base), 32'd0);
        loadRam();
        pushExpected();
        base = doneCnt;
        resBase = resCnt;
        startScan();
        checkVal("rescanRen",  32'(pf.ram_ren),   32'd1);
        checkVal("rescanAddr", 32'(pf.ram_raddr), 32'd0);
        waitDone(base, resBase, "scan3");

        checkVal("sbLeft", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
